// File: rtl/count_stream_monitor.sv
// count_stream_monitor: checks three step-counter lanes against prev + STEPi,
// counts mismatches, snapshots the first pending one and reports lock.
module count_stream_monitor #(
  parameter int WIDTH         = 8,
  parameter int STEP0         = 1,
  parameter int STEP1         = 2,
  parameter int STEP2         = 3,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int LOCK_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_count0,
  input  logic [WIDTH-1:0]         in_count1,
  input  logic [WIDTH-1:0]         in_count2,
  output logic                     err_flag,
  output logic [2:0]               err_mask,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     locked,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [3*WIDTH+2:0]       snap_data
);

  localparam int RUN_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CYCLES);

  typedef enum logic {SYNC, CHECK} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] prev0, prev1, prev2;
  logic [WIDTH-1:0] pred0, pred1, pred2;
  logic [RUN_W-1:0] run, run_inc;
  logic [2:0]       mismatch;
  logic             compare, any_mismatch, drain, capture;

  always_ff @(posedge clk) begin
    if (reset || clear) state <= SYNC;
    else                state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    compare    = 1'b0;
    case (state)
      SYNC:    state_next = CHECK;
      CHECK:   compare    = 1'b1;
      default: state_next = SYNC;
    endcase
  end

  // Predictions wrap naturally by truncation to WIDTH.
  assign pred0 = prev0 + WIDTH'(STEP0);
  assign pred1 = prev1 + WIDTH'(STEP1);
  assign pred2 = prev2 + WIDTH'(STEP2);

  assign mismatch     = compare ? {in_count2 != pred2, in_count1 != pred1, in_count0 != pred0}
                                : 3'b000;
  assign any_mismatch = |mismatch;
  assign run_inc      = (run == RUN_MAX) ? run : run + 1'b1;
  assign drain        = snap_valid && snap_ready;
  assign capture      = any_mismatch && (!snap_valid || snap_ready);

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev0      <= '0;
      prev1      <= '0;
      prev2      <= '0;
      run        <= '0;
      err_flag   <= 1'b0;
      err_mask   <= 3'b000;
      err_count  <= '0;
      locked     <= 1'b0;
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else begin
      // Always re-sync to the actual samples so one glitch costs two compares.
      prev0    <= in_count0;
      prev1    <= in_count1;
      prev2    <= in_count2;
      err_flag <= any_mismatch;

      if (any_mismatch) begin
        err_mask <= err_mask | mismatch;
        if (err_count != '1) err_count <= err_count + 1'b1;
        run    <= '0;
        locked <= 1'b0;
      end else if (compare) begin
        run    <= run_inc;
        locked <= (run_inc == RUN_MAX);
      end

      if (capture) begin
        snap_valid <= 1'b1;
        snap_data  <= {mismatch, in_count2, in_count1, in_count0};
      end else if (drain) begin
        snap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_stream_monitor.sv
// Randomised scoreboard bench for count_stream_monitor: a lane-level reference
// model predicts status and snapshots; monitors compare against two DUT instances.
module tb_count_stream_monitor;

  localparam int LOCK = 4;

  typedef struct {
    logic        flag;
    logic [2:0]  mask;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        lck;
    logic        sv;
    logic [26:0] sd;
  } exp_t;

  logic        clk, reset, clear, snap_ready;
  logic [7:0]  in_count0, in_count1, in_count2;
  logic        err_flag, locked, snap_valid;
  logic [2:0]  err_mask;
  logic [15:0] err_count;
  logic [26:0] snap_data;
  logic        s_err_flag, s_locked, s_snap_valid;
  logic [2:0]  s_err_mask;
  logic [3:0]  s_err_count;
  logic [26:0] s_snap_data;

  count_stream_monitor dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_count0(in_count0), .in_count1(in_count1), .in_count2(in_count2),
    .err_flag(err_flag), .err_mask(err_mask), .err_count(err_count), .locked(locked),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_data(snap_data)
  );

  count_stream_monitor #(.ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .in_count0(in_count0), .in_count1(in_count1), .in_count2(in_count2),
    .err_flag(s_err_flag), .err_mask(s_err_mask), .err_count(s_err_count), .locked(s_locked),
    .snap_valid(s_snap_valid), .snap_ready(snap_ready), .snap_data(s_snap_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  // Reference model state: lane history, counters as plain integers,
  // and the snapshot slot as a queue of values the consumer should receive.
  int          steps[3] = '{1, 2, 3};
  int          cur[3];
  bit          m_have;
  int          m_prev[3];
  logic [2:0]  m_mask;
  int          m_cnt, m_cnt4, m_run;
  bit          m_full, m_flag;
  logic [26:0] m_data;
  exp_t        exp_q[$];
  logic [26:0] snap_q[$];

  task automatic model_edge(input bit rst, input bit clr, input int v[3], input bit rdy);
    logic [2:0] mm;
    bit drain;
    exp_t e;
    if (rst || clr) begin
      if (m_full) void'(snap_q.pop_back());
      m_have = 0; m_mask = 0; m_cnt = 0; m_cnt4 = 0; m_run = 0;
      m_full = 0; m_flag = 0; m_data = '0;
    end else begin
      drain = m_full && rdy;
      mm = 3'b000;
      if (m_have) begin
        for (int i = 0; i < 3; i++) mm[i] = (v[i] != ((m_prev[i] + steps[i]) % 256));
      end
      for (int i = 0; i < 3; i++) m_prev[i] = v[i];
      m_flag = (mm != 0);
      if (mm != 0) begin
        m_mask |= mm;
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
        m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
        m_run  = 0;
        if (!m_full || drain) begin
          m_full = 1;
          m_data = {mm, v[2][7:0], v[1][7:0], v[0][7:0]};
          snap_q.push_back(m_data);
        end
      end else begin
        if (m_have) m_run = (m_run < LOCK) ? m_run + 1 : LOCK;
        if (drain) m_full = 0;
      end
      m_have = 1;
    end
    e.flag = m_flag; e.mask = m_mask; e.cnt = 16'(m_cnt); e.cnt4 = 4'(m_cnt4);
    e.lck = (m_run == LOCK); e.sv = m_full; e.sd = m_data;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic drive(input bit rst, input bit clr, input int v0, input int v1,
                       input int v2, input bit rdy);
    int v[3];
    v[0] = v0 & 255; v[1] = v1 & 255; v[2] = v2 & 255;
    reset = rst; clear = clr; snap_ready = rdy;
    in_count0 = 8'(v[0]); in_count1 = 8'(v[1]); in_count2 = 8'(v[2]);
    model_edge(rst, clr, v, rdy);
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic advance();
    for (int i = 0; i < 3; i++) cur[i] = (cur[i] + steps[i]) % 256;
  endtask

  task automatic run_stream(input int n, input int rdy_mode);
    bit r;
    for (int k = 0; k < n; k++) begin
      r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
      drive(0, 0, cur[0], cur[1], cur[2], r);
      advance();
    end
  endtask

  // Status monitor: one expectation per edge, checked after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("err_flag",   32'(err_flag),    32'(e.flag));
        check("err_mask",   32'(err_mask),    32'(e.mask));
        check("err_count",  32'(err_count),   32'(e.cnt));
        check("locked",     32'(locked),      32'(e.lck));
        check("snap_valid", 32'(snap_valid),  32'(e.sv));
        if (e.sv) check("snap_data_held", 32'(snap_data), 32'(e.sd));
        check("sat_err_count", 32'(s_err_count), 32'(e.cnt4));
        check("sat_snap_valid", 32'(s_snap_valid), 32'(e.sv));
      end
    end
  end

  // Handshake monitor: every transfer must deliver the next expected snapshot.
  initial begin
    logic [26:0] d;
    forever begin
      @(negedge clk);
      if (snap_valid && snap_ready) begin
        if (snap_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL snap_unexpected @cycle %0d: got 0x%0h expected no transfer", cycle, snap_data);
        end else begin
          d = snap_q.pop_front();
          check("snap_xfer", 32'(snap_data), 32'(d));
        end
      end
    end
  end

  initial begin
    int held;
    reset = 1'b1; clear = 1'b0; snap_ready = 1'b0;
    in_count0 = '0; in_count1 = '0; in_count2 = '0;
    m_have = 0; m_mask = 0; m_cnt = 0; m_cnt4 = 0; m_run = 0;
    m_full = 0; m_flag = 0; m_data = '0;
    cur = '{0, 0, 0};

    // Reset, then a clean wrapping stream.
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_snap_data", 32'(snap_data), 32'd0);
    run_stream(5, 2);
    check("lock_after_5", 32'(locked), 32'd1);
    run_stream(295, 2);
    check("clean_err_count", 32'(err_count), 32'd0);
    check("clean_err_mask",  32'(err_mask),  32'd0);

    // Lane 1 glitch to 0x55 where 0x10 is expected.
    while (cur[1] != 8'h10) run_stream(1, 0);
    drive(0, 0, cur[0], 8'h55, cur[2], 0);
    advance();
    check("glitch_flag", 32'(err_flag), 32'd1);
    run_stream(1, 0);
    check("glitch_flag2", 32'(err_flag), 32'd1);
    run_stream(2, 0);
    check("glitch_count", 32'(err_count), 32'd2);
    check("glitch_mask",  32'(err_mask),  32'b010);
    check("glitch_lock",  32'(locked),    32'd0);
    check("glitch_snap_mask", 32'(snap_data[26:24]), 32'b010);
    check("glitch_snap_c1",   32'(snap_data[15:8]),  32'h55);

    // Lane 2 corruption while the snapshot is pending.
    drive(0, 0, cur[0], cur[1], cur[2] ^ 8'h0F, 0);
    advance();
    run_stream(2, 0);
    check("pend_mask", 32'(err_mask), 32'b110);
    check("pend_snap_c1", 32'(snap_data[15:8]), 32'h55);
    run_stream(1, 1);
    check("drained", 32'(snap_valid), 32'd0);

    // Mismatch coinciding with the draining edge reloads the slot.
    drive(0, 0, cur[0] + 7, cur[1], cur[2], 0);
    advance();
    run_stream(1, 1);
    check("reload_valid", 32'(snap_valid), 32'd1);
    check("reload_mask",  32'(snap_data[26:24]), 32'b001);
    run_stream(3, 0);

    // Lane 0 stuck for 20 cycles: 4-bit counter saturates.
    held = cur[0];
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, held, cur[1], cur[2], 1'($urandom_range(0, 1)));
      advance();
    end
    check("sat_15", 32'(s_err_count), 32'd15);
    run_stream(6, 2);

    // Clear together with a mismatch.
    drive(0, 1, cur[0], cur[1] + 3, cur[2], 0);
    advance();
    check("clear_count", 32'(err_count), 32'd0);
    check("clear_flag",  32'(err_flag),  32'd0);
    check("clear_valid", 32'(snap_valid), 32'd0);
    run_stream(10, 2);
    check("post_clear_count", 32'(err_count), 32'd0);
    check("post_clear_lock",  32'(locked),    32'd1);

    // Reset mid-stream with a pending snapshot, restart at 0x80/0x81/0x82.
    drive(0, 0, cur[0], cur[1], cur[2] + 9, 0);
    advance();
    run_stream(1, 0);
    drive(1, 0, cur[0], cur[1], cur[2], 0);
    drive(1, 0, cur[0], cur[1], cur[2], 0);
    check("rst_valid", 32'(snap_valid), 32'd0);
    check("rst_count", 32'(err_count),  32'd0);
    cur = '{8'h80, 8'h81, 8'h82};
    run_stream(20, 2);
    check("restart_count", 32'(err_count), 32'd0);
    check("restart_lock",  32'(locked),    32'd1);

    // Random glitches, handshakes and occasional clears/resets.
    for (int k = 0; k < 600; k++) begin
      int v[3];
      bit rst, clr, rdy;
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 79) == 0);
      rdy = (rst || clr) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++)
        v[i] = ($urandom_range(0, 15) == 0) ? cur[i] + int'($urandom_range(1, 255)) : cur[i];
      drive(rst, clr, v[0], v[1], v[2], rdy);
      advance();
    end

    // Drain whatever is left and confirm nothing is outstanding.
    run_stream(6, 1);
    @(posedge clk);
    #3;
    check("snap_queue_empty", 32'(snap_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
